// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared types and constants for the digit-serial adder controller.
//   sadd_state_e  : controller FSM states (idle / running / result held)
//   SADD_DIGIT_W  : number of sum bits produced per clock by the adder slice
// -----------------------------------------------------------------------------
package serial_add_pkg;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sadd_state_e;

   localparam int SADD_DIGIT_W = 2;

endpackage

// File: rtl/two_bit_adder.sv
// -----------------------------------------------------------------------------
// two_bit_adder
// Purely combinational 2-bit ripple-carry adder slice.
// Ports:
//   A, B   : 2-bit addends
//   C_in   : carry into bit 0
//   Sum    : 2-bit sum
//   C_out  : carry out of bit 1
// -----------------------------------------------------------------------------
module two_bit_adder (
   input  logic [1:0] A,
   input  logic [1:0] B,
   input  logic       C_in,
   output logic [1:0] Sum,
   output logic       C_out
);

   // carry[gi] is the carry into bit gi
   logic [2:0] carry;
   genvar gi;

   assign carry[0] = C_in;

   generate
      for (gi = 0; gi < 2; gi++) begin : g_fa
         assign Sum[gi]     = A[gi] ^ B[gi] ^ carry[gi];
         assign carry[gi+1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
      end
   endgenerate

   assign C_out = carry[2];

endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Area-reduced WIDTH-bit adder: computes A + B + Cin by reusing one 2-bit
// adder slice, least-significant digit first, over WIDTH/2 clock cycles.
//
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_valid / o_ready : request handshake (accepted only in IDLE)
//   i_a, i_b, i_cin   : operands, sampled at the acceptance edge only
//   o_valid / i_ready : result handshake (result held until i_ready)
//   o_sum, o_cout     : WIDTH-bit sum and carry-out, zero unless o_valid
//   o_busy            : high while an operation is running or being held
//   o_ovf             : signed overflow flag, only when SERIAL_ADD_OVF_EN
//                       is defined
//
// Optional feature macro: SERIAL_ADD_OVF_EN
// -----------------------------------------------------------------------------
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_busy
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             o_ovf
`endif
);

   localparam int CNT_W  = $clog2(WIDTH / 2) + 1;
   localparam int N_DIG  = WIDTH / SADD_DIGIT_W;
   localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(N_DIG - 1);

   generate
      if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
         $error("serial_add_ctrl: WIDTH must be even and >= 4");
      end
   endgenerate

   sadd_state_e               state_reg;
   logic [WIDTH-1:0]          a_sr;
   logic [WIDTH-1:0]          b_sr;
   logic [WIDTH-1:0]          sum_sr;
   logic                      carry_reg;
   logic [CNT_W-1:0]          cnt_reg;
   logic                      ready_reg;
   logic                      valid_reg;
   logic                      busy_reg;

   logic [SADD_DIGIT_W-1:0]   slice_sum;
   logic                      slice_cout;

   // The single shared slice always works on the low digit of the operand
   // shift registers; the FSM decides whether its result is captured.
   two_bit_adder u_slice (
      .A     (a_sr[SADD_DIGIT_W-1:0]),
      .B     (b_sr[SADD_DIGIT_W-1:0]),
      .C_in  (carry_reg),
      .Sum   (slice_sum),
      .C_out (slice_cout)
   );

`ifdef SERIAL_ADD_OVF_EN
   logic a_msb_reg;
   logic b_msb_reg;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= S_IDLE;
         a_sr      <= '0;
         b_sr      <= '0;
         sum_sr    <= '0;
         carry_reg <= 1'b0;
         cnt_reg   <= '0;
         ready_reg <= 1'b1;
         valid_reg <= 1'b0;
         busy_reg  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         a_msb_reg <= 1'b0;
         b_msb_reg <= 1'b0;
`endif
      end else begin
         unique case (state_reg)
            S_IDLE: begin
               if (i_valid) begin
                  a_sr      <= i_a;
                  b_sr      <= i_b;
                  carry_reg <= i_cin;
                  cnt_reg   <= '0;
                  state_reg <= S_RUN;
                  ready_reg <= 1'b0;
                  busy_reg  <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                  a_msb_reg <= i_a[WIDTH-1];
                  b_msb_reg <= i_b[WIDTH-1];
`endif
               end
            end
            S_RUN: begin
               // Operands drain from the bottom, sum digits fill from the
               // top, so after N_DIG steps sum_sr is in natural bit order.
               a_sr      <= {{SADD_DIGIT_W{1'b0}}, a_sr[WIDTH-1:SADD_DIGIT_W]};
               b_sr      <= {{SADD_DIGIT_W{1'b0}}, b_sr[WIDTH-1:SADD_DIGIT_W]};
               sum_sr    <= {slice_sum, sum_sr[WIDTH-1:SADD_DIGIT_W]};
               carry_reg <= slice_cout;
               cnt_reg   <= cnt_reg + CNT_W'(1);
               if (cnt_reg == LAST_DIG) begin
                  state_reg <= S_DONE;
                  valid_reg <= 1'b1;
               end
            end
            S_DONE: begin
               if (i_ready) begin
                  state_reg <= S_IDLE;
                  valid_reg <= 1'b0;
                  busy_reg  <= 1'b0;
                  ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= S_IDLE;
               valid_reg <= 1'b0;
               busy_reg  <= 1'b0;
               ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign o_ready = ready_reg;
   assign o_valid = valid_reg;
   assign o_busy  = busy_reg;
   // Result lines read as zero whenever no result is being offered.
   assign o_sum   = valid_reg ? sum_sr : '0;
   assign o_cout  = valid_reg & carry_reg;

`ifdef SERIAL_ADD_OVF_EN
   assign o_ovf = valid_reg && (a_msb_reg == b_msb_reg) && (sum_sr[WIDTH-1] != a_msb_reg);
`endif

endmodule
